uart_rx_os: RTL and testbench

Parametrised oversampling UART receiver and successor to the single-rate `uart_receive`. It runs directly on `sys_clk` with an internal baud/oversample tick, so no derived UART clock is needed. Data width, parity mode and stop-bit count are configurable, and framing, parity and break errors are reported. It sits between the board RX pin and the byte-level protocol logic, beside the existing `uart_send`.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_os_tick.sv | 35 +++
 rtl/uart_rx_os.sv | 207 ++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampled UART blocks.
//   parity_e   : parity mode encoding (NONE / EVEN / ODD)
//   rx_state_e : receiver state machine states
//   calc_div   : sys_clk cycles per oversample tick, rounded to nearest
package uart_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_e;

  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    return (clk_hz + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick generator: one-cycle o_tick every DIV sys_clk cycles.
// Ports:
//   sys_clk   in  : clock
//   sys_reset in  : synchronous active-high reset
//   i_clear   in  : holds the divider at zero (phase realigns on release)
//   o_tick    out : one-cycle tick, first one DIV cycles after i_clear drops
module uart_os_tick
  import uart_pkg::*;
#(
  parameter int DIV = 27
) (
  input  logic sys_clk,
  input  logic sys_reset,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge sys_clk) begin
    if (sys_reset || i_clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign o_tick = (cnt == LAST) && !i_clear;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver running directly on sys_clk.
// Ports:
//   sys_clk            in  : clock
//   sys_reset          in  : synchronous active-high reset
//   uart_rx            in  : asynchronous serial line, idle high
//   o_receive_data     out : last received word, LSB = first data bit
//   o_receive_data_en  out : one-cycle pulse at frame end
//   o_parity_err       out : parity mismatch on last frame
//   o_frame_err        out : a stop bit sampled low on last frame
//   o_break            out : all data/parity/stop bits sampled low
//   uart_busy          out : high from start detection to frame end
module uart_rx_os #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_reset,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] o_receive_data,
  output logic                 o_receive_data_en,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_break,
  output logic                 uart_busy
);

  import uart_pkg::*;

  localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);

  if (!(OVERSAMPLE == 8 || OVERSAMPLE == 16)) begin : g_bad_os
    $error("uart_rx_os: OVERSAMPLE must be 8 or 16");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_rx_os: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_rx_os: PARITY must be 0, 1 or 2");
  end
  if (!(STOP_BITS == 1 || STOP_BITS == 2)) begin : g_bad_stop
    $error("uart_rx_os: STOP_BITS must be 1 or 2");
  end
  if (DIV < 2) begin : g_bad_div
    $error("uart_rx_os: baud divider must be at least 2");
  end

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_S0   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] OS_S1   = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0] OS_DEC  = OS_W'(OVERSAMPLE / 2 + 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [3:0]      LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic            LAST_STOP = 1'(STOP_BITS - 1);
  localparam bit              PAR_EN  = (PARITY != 0);
  localparam bit              PAR_ODD = (PARITY == int'(ODD));

  rx_state_e state, state_nxt;

  logic                 rx_meta, rx_sync;
  logic                 tick;
  logic [OS_W-1:0]      os_cnt;
  logic [3:0]           bit_cnt;
  logic                 stop_cnt;
  logic                 samp_a, samp_b;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;
  logic                 stop_low;
  logic                 any_one;
  logic                 vote;
  logic                 decide;
  logic                 bit_end;
  logic                 frame_end;

  // Two-flop synchroniser; resets to the idle-high line level so a reset
  // never looks like a start edge.
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
    end
  end

  // Divider is held while waiting so the sample phase starts at the edge.
  uart_os_tick #(
    .DIV (DIV)
  ) u_tick (
    .sys_clk   (sys_clk),
    .sys_reset (sys_reset),
    .i_clear   ((state == IDLE) || (state == WAIT_IDLE)),
    .o_tick    (tick)
  );

  // Third vote sample is the live synchronised line at the decision tick.
  assign vote    = (samp_a & samp_b) | (samp_a & rx_sync) | (samp_b & rx_sync);
  assign decide  = tick && (os_cnt == OS_DEC);
  assign bit_end = tick && (os_cnt == OS_LAST);

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    frame_end = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_sync) state_nxt = START;
      end
      START: begin
        if (decide && vote) state_nxt = IDLE;
        else if (bit_end)   state_nxt = DATA;
      end
      DATA: begin
        if (bit_end && (bit_cnt == LAST_DATA))
          state_nxt = PAR_EN ? uart_pkg::PARITY : STOP;
      end
      uart_pkg::PARITY: begin
        if (bit_end) state_nxt = STOP;
      end
      STOP: begin
        // The frame closes at the decision of the last stop bit, leaving
        // the rest of that bit for catching the next start edge.
        if (decide && (stop_cnt == LAST_STOP)) begin
          frame_end = 1'b1;
          state_nxt = (stop_low || !vote) ? WAIT_IDLE : IDLE;
        end
      end
      WAIT_IDLE: begin
        if (rx_sync) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign uart_busy = (state != IDLE) && (state != WAIT_IDLE);

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      os_cnt            <= '0;
      bit_cnt           <= '0;
      stop_cnt          <= 1'b0;
      samp_a            <= 1'b1;
      samp_b            <= 1'b1;
      shift             <= '0;
      par_bit           <= 1'b0;
      stop_low          <= 1'b0;
      any_one           <= 1'b0;
      o_receive_data    <= '0;
      o_receive_data_en <= 1'b0;
      o_parity_err      <= 1'b0;
      o_frame_err       <= 1'b0;
      o_break           <= 1'b0;
    end else begin
      o_receive_data_en <= frame_end;
      if ((state == IDLE) || (state == WAIT_IDLE)) begin
        os_cnt   <= '0;
        bit_cnt  <= '0;
        stop_cnt <= 1'b0;
        stop_low <= 1'b0;
        any_one  <= 1'b0;
      end else if (tick) begin
        os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
        if (os_cnt == OS_S0) samp_a <= rx_sync;
        if (os_cnt == OS_S1) samp_b <= rx_sync;
        if (os_cnt == OS_DEC) begin
          case (state)
            DATA: begin
              shift   <= {vote, shift[DATA_BITS-1:1]};
              any_one <= any_one | vote;
            end
            uart_pkg::PARITY: begin
              par_bit <= vote;
              any_one <= any_one | vote;
            end
            STOP: begin
              stop_low <= stop_low | !vote;
              any_one  <= any_one | vote;
            end
            default: ;
          endcase
        end
        if (os_cnt == OS_LAST) begin
          if (state == DATA) bit_cnt  <= bit_cnt + 1'b1;
          if (state == STOP) stop_cnt <= stop_cnt + 1'b1;
        end
      end
      if (frame_end) begin
        o_receive_data <= shift;
        o_frame_err    <= stop_low | !vote;
        o_break        <= !(any_one | vote);
        o_parity_err   <= PAR_EN && (par_bit != ((^shift) ^ PAR_ODD));
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os. Three receivers with different
// configurations share clock and reset; each has its own line, expected
// queue and monitor.
//   ch0: defaults (8N1)   ch1: 8E1   ch2: 7O2
module tb_uart_rx_os;

  localparam int BIT_CYC = 432;

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } exp_t;

  logic       sys_clk = 1'b0;
  logic       sys_reset;
  logic       rx0, rx1, rx2;

  logic [7:0] d0_data, d1_data;
  logic [6:0] d2_data;
  logic       d0_en, d0_perr, d0_ferr, d0_brk, d0_busy;
  logic       d1_en, d1_perr, d1_ferr, d1_brk, d1_busy;
  logic       d2_en, d2_perr, d2_ferr, d2_brk, d2_busy;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int   pulse_t0[$];
  int   pulses0 = 0, pulses1 = 0, pulses2 = 0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc++;

  uart_rx_os dut0 (
    .sys_clk (sys_clk), .sys_reset (sys_reset), .uart_rx (rx0),
    .o_receive_data (d0_data), .o_receive_data_en (d0_en),
    .o_parity_err (d0_perr), .o_frame_err (d0_ferr), .o_break (d0_brk),
    .uart_busy (d0_busy)
  );

  uart_rx_os #(.PARITY(1)) dut1 (
    .sys_clk (sys_clk), .sys_reset (sys_reset), .uart_rx (rx1),
    .o_receive_data (d1_data), .o_receive_data_en (d1_en),
    .o_parity_err (d1_perr), .o_frame_err (d1_ferr), .o_break (d1_brk),
    .uart_busy (d1_busy)
  );

  uart_rx_os #(.DATA_BITS(7), .STOP_BITS(2), .PARITY(2)) dut2 (
    .sys_clk (sys_clk), .sys_reset (sys_reset), .uart_rx (rx2),
    .o_receive_data (d2_data), .o_receive_data_en (d2_en),
    .o_parity_err (d2_perr), .o_frame_err (d2_ferr), .o_break (d2_brk),
    .uart_busy (d2_busy)
  );

  task automatic checkOutput(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic compare_frame(input string ch, input logic [8:0] data, input logic perr,
                               input logic ferr, input logic brk, input exp_t e);
    checkOutput({ch, " data"}, 32'(data), 32'(e.data));
    checkOutput({ch, " parity_err"}, 32'(perr), 32'(e.perr));
    checkOutput({ch, " frame_err"}, 32'(ferr), 32'(e.ferr));
    checkOutput({ch, " break"}, 32'(brk), 32'(e.brk));
  endtask

  task automatic set_line(input int ch, input logic v);
    case (ch)
      0: rx0 = v;
      1: rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  task automatic line_idle(input int ch, input int cycles);
    set_line(ch, 1'b1);
    repeat (cycles) @(negedge sys_clk);
  endtask

  // Drives nbits of a frame (bit 0 first) on one line, bit_cyc cycles per bit.
  task automatic applyStimulus(input int ch, input logic [15:0] frame, input int nbits,
                               input int bit_cyc);
    for (int i = 0; i < nbits; i++) begin
      set_line(ch, frame[i]);
      repeat (bit_cyc) @(negedge sys_clk);
    end
  endtask

  function automatic logic [15:0] mk_frame(input logic [8:0] data, input int dbits,
                                           input int npar, input logic par_bit,
                                           input int nstop, input logic stop_val);
    logic [15:0] f;
    int k;
    f = '1;
    f[0] = 1'b0;
    k = 1;
    for (int i = 0; i < dbits; i++) begin
      f[k] = data[i];
      k++;
    end
    if (npar != 0) begin
      f[k] = par_bit;
      k++;
    end
    for (int s = 0; s < nstop; s++) begin
      f[k] = stop_val;
      k++;
    end
    return f;
  endfunction

  function automatic exp_t mk_exp(input logic [8:0] d, input logic p, input logic f, input logic b);
    exp_t e;
    e.data = d; e.perr = p; e.ferr = f; e.brk = b;
    return e;
  endfunction

  // Monitors: each pulse is matched against the oldest expected frame.
  always @(negedge sys_clk) begin
    if (d0_en) begin
      pulses0++;
      pulse_t0.push_back(cyc);
      checkOutput("ch0 busy low at pulse", 32'(d0_busy), 32'd0);
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL ch0 unexpected pulse: data 0x%0h, none expected", d0_data);
      end else begin
        compare_frame("ch0", {1'b0, d0_data}, d0_perr, d0_ferr, d0_brk, q0.pop_front());
      end
    end
  end

  always @(negedge sys_clk) begin
    if (d1_en) begin
      pulses1++;
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL ch1 unexpected pulse: data 0x%0h, none expected", d1_data);
      end else begin
        compare_frame("ch1", {1'b0, d1_data}, d1_perr, d1_ferr, d1_brk, q1.pop_front());
      end
    end
  end

  always @(negedge sys_clk) begin
    if (d2_en) begin
      pulses2++;
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL ch2 unexpected pulse: data 0x%0h, none expected", d2_data);
      end else begin
        compare_frame("ch2", {2'b0, d2_data}, d2_perr, d2_ferr, d2_brk, q2.pop_front());
      end
    end
  end

  initial begin
    repeat (95000) @(posedge sys_clk);
    $display("[TB] FAIL watchdog: cycle budget expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
    sys_reset = 1'b1;
    repeat (4) @(negedge sys_clk);
    checkOutput("reset data", 32'(d0_data), 32'd0);
    checkOutput("reset data_en", 32'(d0_en), 32'd0);
    checkOutput("reset flags", 32'({d0_perr, d0_ferr, d0_brk}), 32'd0);
    checkOutput("reset busy", 32'({d0_busy, d1_busy, d2_busy}), 32'd0);
    sys_reset = 1'b0;
    line_idle(0, 2 * BIT_CYC);

    $display("[TB] 8N1 back-to-back 0x55, 0xA3");
    q0.push_back(mk_exp(9'h055, 1'b0, 1'b0, 1'b0));
    q0.push_back(mk_exp(9'h0A3, 1'b0, 1'b0, 1'b0));
    applyStimulus(0, mk_frame(9'h055, 8, 0, 1'b0, 1, 1'b1), 10, BIT_CYC);
    applyStimulus(0, mk_frame(9'h0A3, 8, 0, 1'b0, 1, 1'b1), 10, BIT_CYC);
    line_idle(0, 2 * BIT_CYC);
    checkOutput("back-to-back pulse count", 32'(pulses0), 32'd2);
    if (pulse_t0.size() >= 2)
      checkOutput("back-to-back pulse spacing", 32'(pulse_t0[1] - pulse_t0[0]), 32'(10 * BIT_CYC));
    else
      checkOutput("back-to-back pulse spacing", 32'(pulse_t0.size()), 32'd2);

    $display("[TB] 8N1 0x3C with low stop bit");
    q0.push_back(mk_exp(9'h03C, 1'b0, 1'b1, 1'b0));
    applyStimulus(0, mk_frame(9'h03C, 8, 0, 1'b0, 1, 1'b0), 10, BIT_CYC);
    set_line(0, 1'b0);
    repeat (2 * BIT_CYC) @(negedge sys_clk);
    line_idle(0, 2 * BIT_CYC);
    checkOutput("frame_err single pulse", 32'(pulses0), 32'd3);
    q0.push_back(mk_exp(9'h055, 1'b0, 1'b0, 1'b0));
    applyStimulus(0, mk_frame(9'h055, 8, 0, 1'b0, 1, 1'b1), 10, BIT_CYC);
    line_idle(0, 2 * BIT_CYC);
    checkOutput("recovery after frame_err", 32'(pulses0), 32'd4);

    // Line held low across a whole frame and three more bit times.
    $display("[TB] 8N1 break");
    q0.push_back(mk_exp(9'h000, 1'b0, 1'b1, 1'b1));
    set_line(0, 1'b0);
    repeat (13 * BIT_CYC) @(negedge sys_clk);
    line_idle(0, 2 * BIT_CYC);
    checkOutput("break single pulse", 32'(pulses0), 32'd5);

    $display("[TB] 8N1 100-cycle glitch");
    set_line(0, 1'b0);
    repeat (2) @(negedge sys_clk);
    checkOutput("busy not yet risen", 32'(d0_busy), 32'd0);
    @(negedge sys_clk);
    checkOutput("busy rises after 3 cycles", 32'(d0_busy), 32'd1);
    repeat (97) @(negedge sys_clk);
    line_idle(0, BIT_CYC);
    checkOutput("busy after false start", 32'(d0_busy), 32'd0);
    checkOutput("no pulse on glitch", 32'(pulses0), 32'd5);

    $display("[TB] 8N1 reset mid-DATA, then 0x81");
    applyStimulus(0, mk_frame(9'h012, 8, 0, 1'b0, 1, 1'b1), 5, BIT_CYC);
    sys_reset = 1'b1;
    set_line(0, 1'b1);
    repeat (2) @(negedge sys_clk);
    checkOutput("busy cleared by reset", 32'(d0_busy), 32'd0);
    sys_reset = 1'b0;
    line_idle(0, BIT_CYC);
    q0.push_back(mk_exp(9'h081, 1'b0, 1'b0, 1'b0));
    applyStimulus(0, mk_frame(9'h081, 8, 0, 1'b0, 1, 1'b1), 10, BIT_CYC);
    line_idle(0, 2 * BIT_CYC);
    checkOutput("only 0x81 after reset", 32'(pulses0), 32'd6);

    // 0xA3 has four ones, so the even parity bit is 0.
    $display("[TB] 8E1 parity");
    q1.push_back(mk_exp(9'h0A3, 1'b0, 1'b0, 1'b0));
    applyStimulus(1, mk_frame(9'h0A3, 8, 1, 1'b0, 1, 1'b1), 11, BIT_CYC);
    line_idle(1, 2 * BIT_CYC);
    q1.push_back(mk_exp(9'h0A3, 1'b1, 1'b0, 1'b0));
    applyStimulus(1, mk_frame(9'h0A3, 8, 1, 1'b1, 1, 1'b1), 11, BIT_CYC);
    line_idle(1, 2 * BIT_CYC);

    // 7-bit 0x5A has four ones, so the odd parity bit is 1.
    $display("[TB] 7O2 at +2%% and -2%% baud");
    q2.push_back(mk_exp(9'h05A, 1'b0, 1'b0, 1'b0));
    applyStimulus(2, mk_frame(9'h05A, 7, 1, 1'b1, 2, 1'b1), 11, 424);
    line_idle(2, 2 * BIT_CYC);
    q2.push_back(mk_exp(9'h05A, 1'b0, 1'b0, 1'b0));
    applyStimulus(2, mk_frame(9'h05A, 7, 1, 1'b1, 2, 1'b1), 11, 441);
    line_idle(2, 2 * BIT_CYC);

    checkOutput("ch0 expected frames left", 32'(q0.size()), 32'd0);
    checkOutput("ch1 pulse count", 32'(pulses1), 32'd2);
    checkOutput("ch1 expected frames left", 32'(q1.size()), 32'd0);
    checkOutput("ch2 pulse count", 32'(pulses2), 32'd2);
    checkOutput("ch2 expected frames left", 32'(q2.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
